// File: rtl/intr_ctrl.sv
// intr_ctrl: prioritised interrupt controller with built-in machine timer.
// Define INTR_SYNC_EN to add a 2-flop synchroniser on every src_irq line.
module intr_ctrl #(
  parameter int NUM_SRC  = 8,
  parameter int TIMER_W  = 64,
  parameter int PRESCALE = 1,
  parameter int ID_W     = $clog2(NUM_SRC + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] src_irq,
  input  logic               reg_wr,
  input  logic               reg_rd,
  input  logic [2:0]         reg_addr,
  input  logic [31:0]        reg_wdata,
  output logic [31:0]        reg_rdata,
  output logic               irq_req,
  output logic [ID_W-1:0]    irq_id,
  input  logic               irq_ack,
  input  logic               irq_done
);

  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int HI_W = TIMER_W - 32;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    SERVICE
  } state_t;

  state_t state;

  logic [TIMER_W-1:0] mtime;
  logic [TIMER_W-1:0] mtimecmp;
  logic [PS_W-1:0]    ps_cnt;
  logic               ps_tick;
  logic [NUM_SRC:0]   enable;
  logic [NUM_SRC-1:0] mode;
  logic [NUM_SRC-1:0] spend;
  logic [NUM_SRC-1:0] src_s;
  logic [NUM_SRC-1:0] src_d;
  logic [NUM_SRC-1:0] edge_set;
  logic [NUM_SRC-1:0] clr;
  logic [NUM_SRC:0]   pending;
  logic [NUM_SRC:0]   cand;
  logic [NUM_SRC:0]   id_oh;
  logic [ID_W-1:0]    winner;
  logic               tpend;
  logic [31:0]        rd_mux;

`ifdef INTR_SYNC_EN
  logic [NUM_SRC-1:0] src_m;

  // two-stage synchroniser for asynchronous sources
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      src_m <= '0;
      src_s <= '0;
    end else begin
      src_m <= src_irq;
      src_s <= src_m;
    end
  end
`else
  // single capture register for sources already in this clock domain
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) src_s <= '0;
    else      src_s <= src_irq;
  end
`endif

  // previous synchronised level, used for rising-edge detection
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) src_d <= '0;
    else      src_d <= src_s;
  end

  assign ps_tick = (ps_cnt == PS_W'(PRESCALE - 1));

  // prescaler: one mtime tick every PRESCALE cycles
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         ps_cnt <= '0;
    else if (ps_tick) ps_cnt <= '0;
    else              ps_cnt <= ps_cnt + 1'b1;
  end

  // mtime: software write beats a concurrent tick
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mtime <= '0;
    end else if (reg_wr && reg_addr == 3'd0) begin
      mtime[31:0] <= reg_wdata;
    end else if (reg_wr && reg_addr == 3'd1) begin
      mtime[TIMER_W-1:32] <= reg_wdata[HI_W-1:0];
    end else if (ps_tick) begin
      mtime <= mtime + 1'b1;
    end
  end

  // software-visible configuration registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mtimecmp <= '1;
      enable   <= '0;
      mode     <= '0;
    end else if (reg_wr) begin
      unique case (reg_addr)
        3'd2: mtimecmp[31:0] <= reg_wdata;
        3'd3: mtimecmp[TIMER_W-1:32] <= reg_wdata[HI_W-1:0];
        3'd4: enable <= reg_wdata[NUM_SRC:0];
        3'd6: mode <= reg_wdata[NUM_SRC:1];
        default: ;
      endcase
    end
  end

  assign tpend   = (mtime >= mtimecmp);
  assign pending = {spend, tpend};
  assign cand    = pending & enable;
  assign id_oh   = (NUM_SRC + 1)'(1) << irq_id;

  // edge-pending clear sources: W1C write and ack of the winner
  always_comb begin
    edge_set = src_s & ~src_d;
    clr      = '0;
    if (reg_wr && reg_addr == 3'd5)
      clr = reg_wdata[NUM_SRC:1];
    if (state == REQ && irq_ack)
      clr = clr | id_oh[NUM_SRC:1];
  end

  // source pending: level follows input, edge is sticky with set priority
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) spend <= '0;
    else      spend <= (mode & (edge_set | (spend & ~clr)))
                     | (~mode & src_s);
  end

  // lowest candidate ID wins; timer (ID 0) is highest priority
  always_comb begin
    winner = '0;
    for (int i = NUM_SRC; i >= 0; i--)
      if (cand[i]) winner = ID_W'(i);
  end

  // request/service handshake with the core
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      irq_req <= 1'b0;
      irq_id  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (|cand) begin
            irq_id  <= winner;
            irq_req <= 1'b1;
            state   <= REQ;
          end
        end
        REQ: begin
          if (irq_ack) begin
            irq_req <= 1'b0;
            state   <= SERVICE;
          end else if (~|(cand & id_oh)) begin
            irq_req <= 1'b0;
            state   <= IDLE;
          end
        end
        SERVICE: begin
          if (irq_done) state <= IDLE;
        end
        default: begin
          irq_req <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

  // register read decode
  always_comb begin
    rd_mux = '0;
    unique case (reg_addr)
      3'd0: rd_mux = mtime[31:0];
      3'd1: rd_mux = 32'(mtime[TIMER_W-1:32]);
      3'd2: rd_mux = mtimecmp[31:0];
      3'd3: rd_mux = 32'(mtimecmp[TIMER_W-1:32]);
      3'd4: rd_mux = 32'(enable);
      3'd5: rd_mux = 32'(pending);
      3'd6: rd_mux = 32'({mode, 1'b0});
      default: begin
        rd_mux     = 32'(irq_id);
        rd_mux[31] = (state == SERVICE);
      end
    endcase
  end

  // registered read data, held while reg_rd is low
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        reg_rdata <= '0;
    else if (reg_rd) reg_rdata <= rd_mux;
  end

endmodule

// File: tb/tb_intr_ctrl.sv
// tb_intr_ctrl: directed and randomized checks of intr_ctrl
// against a cycle-level behavioural model.
module tb_intr_ctrl;

  localparam int NS = 8;
  localparam int IW = 4;
  localparam int PS = 1;
`ifdef INTR_SYNC_EN
  localparam int D = 2;
`else
  localparam int D = 1;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [NS-1:0] src_irq = '0;
  logic          reg_wr = 1'b0;
  logic          reg_rd = 1'b0;
  logic [2:0]    reg_addr = '0;
  logic [31:0]   reg_wdata = '0;
  logic [31:0]   reg_rdata;
  logic          irq_req;
  logic [IW-1:0] irq_id;
  logic          irq_ack = 1'b0;
  logic          irq_done = 1'b0;

  int tests = 0;
  int fails = 0;

  intr_ctrl #(
    .NUM_SRC (NS),
    .TIMER_W (64),
    .PRESCALE(PS)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .src_irq  (src_irq),
    .reg_wr   (reg_wr),
    .reg_rd   (reg_rd),
    .reg_addr (reg_addr),
    .reg_wdata(reg_wdata),
    .reg_rdata(reg_rdata),
    .irq_req  (irq_req),
    .irq_id   (irq_id),
    .irq_ack  (irq_ack),
    .irq_done (irq_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      if (fails < 40)
        $display("FAIL %s: got %h expected %h at %0t",
                 name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  longint unsigned m_time;
  longint unsigned m_cmp;
  int              m_ps;
  bit [NS:0]       m_en;
  bit [NS:1]       m_mode;
  bit [NS:1]       m_pend;
  bit [NS-1:0]     samp [0:3];
  int              m_st;
  bit              m_req;
  int              m_id;
  logic [31:0]     m_rdata;

  function automatic logic [31:0] m_read(input int a,
                                         input bit [NS:0] p);
    logic [31:0] v;
    v = '0;
    case (a)
      0: v = m_time[31:0];
      1: v = m_time[63:32];
      2: v = m_cmp[31:0];
      3: v = m_cmp[63:32];
      4: v = 32'(m_en);
      5: v = 32'(p);
      6: v = 32'({m_mode, 1'b0});
      default: begin
        v = 32'(m_id);
        v[31] = (m_st == 2);
      end
    endcase
    return v;
  endfunction

  task automatic m_reset();
    m_time = 0;
    m_cmp = '1;
    m_ps = 0;
    m_en = '0;
    m_mode = '0;
    m_pend = '0;
    for (int k = 0; k < 4; k++) samp[k] = '0;
    m_st = 0;
    m_req = 0;
    m_id = 0;
    m_rdata = '0;
  endtask

  task automatic m_step();
    bit [NS:0] pend;
    bit [NS:0] cand;
    bit [NS:1] nxt;
    int win;
    bit s, p, w1c, ackc, tick;
    pend = {m_pend, (m_time >= m_cmp)};
    cand = pend & m_en;
    win = -1;
    for (int i = 0; i <= NS; i++)
      if (cand[i] && win < 0) win = i;
    if (reg_rd) m_rdata = m_read(int'(reg_addr), pend);
    for (int id = 1; id <= NS; id++) begin
      s = samp[D-1][id-1];
      p = samp[D][id-1];
      w1c = reg_wr && reg_addr == 3'd5 && reg_wdata[id];
      ackc = (m_st == 1) && irq_ack && (m_id == id);
      if (!m_mode[id])   nxt[id] = s;
      else if (s && !p)  nxt[id] = 1'b1;
      else if (w1c || ackc) nxt[id] = 1'b0;
      else               nxt[id] = m_pend[id];
    end
    case (m_st)
      0: if (win >= 0) begin
        m_id = win;
        m_req = 1;
        m_st = 1;
      end
      1: if (irq_ack) begin
        m_req = 0;
        m_st = 2;
      end else if (!cand[m_id]) begin
        m_req = 0;
        m_st = 0;
      end
      default: if (irq_done) m_st = 0;
    endcase
    tick = (m_ps == PS - 1);
    m_ps = tick ? 0 : m_ps + 1;
    if (reg_wr && reg_addr == 3'd0)      m_time[31:0] = reg_wdata;
    else if (reg_wr && reg_addr == 3'd1) m_time[63:32] = reg_wdata;
    else if (tick)                       m_time = m_time + 1;
    if (reg_wr) begin
      case (reg_addr)
        3'd2: m_cmp[31:0] = reg_wdata;
        3'd3: m_cmp[63:32] = reg_wdata;
        3'd4: m_en = reg_wdata[NS:0];
        3'd6: m_mode = reg_wdata[NS:1];
        default: ;
      endcase
    end
    m_pend = nxt;
    for (int k = 3; k > 0; k--) samp[k] = samp[k-1];
    samp[0] = src_irq;
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) m_reset();
    else      m_step();
  end

  // every-cycle comparison against the model
  always @(negedge clk) begin
    if (rst) begin
      chk("cyc_irq_req", 32'(irq_req), 32'(m_req));
      chk("cyc_irq_id", 32'(irq_id), 32'(m_id));
      chk("cyc_rdata", reg_rdata, m_rdata);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int a, input logic [31:0] d);
    reg_wr = 1'b1;
    reg_addr = 3'(a);
    reg_wdata = d;
    cyc();
    reg_wr = 1'b0;
  endtask

  task automatic rd(input int a, output logic [31:0] d);
    reg_rd = 1'b1;
    reg_addr = 3'(a);
    cyc();
    reg_rd = 1'b0;
    d = reg_rdata;
  endtask

  task automatic pulse_ack();
    irq_ack = 1'b1;
    cyc();
    irq_ack = 1'b0;
  endtask

  task automatic pulse_done();
    irq_done = 1'b1;
    cyc();
    irq_done = 1'b0;
  endtask

  initial begin
    logic [31:0] d;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    // reset defaults
    chk("rst_req", 32'(irq_req), 32'h0);
    rd(2, d); chk("rst_cmp_lo", d, 32'hFFFF_FFFF);
    rd(3, d); chk("rst_cmp_hi", d, 32'hFFFF_FFFF);
    rd(4, d); chk("rst_enable", d, 32'h0);

    // timer compare at mtime = 10
    wr(2, 10);
    wr(3, 0);
    wr(0, 0);
    wr(4, 1);
    repeat (9) cyc();
    chk("tmr_pre", 32'(irq_req), 32'h0);
    cyc();
    chk("tmr_req", 32'(irq_req), 32'h1);
    chk("tmr_id", 32'(irq_id), 32'h0);
    pulse_ack();
    chk("tmr_ack", 32'(irq_req), 32'h0);
    rd(7, d); chk("tmr_status", d, 32'h8000_0000);
    pulse_done();
    cyc();
    chk("tmr_rereq", 32'(irq_req), 32'h1);
    wr(2, 32'hFFFF_FFFF);
    cyc();
    chk("tmr_withdraw", 32'(irq_req), 32'h0);
    repeat (3) cyc();
    chk("tmr_quiet", 32'(irq_req), 32'h0);
    wr(4, 0);

    // edge source ID 1
    wr(6, 2);
    wr(4, 2);
    src_irq[0] = 1'b1;
    cyc();
    src_irq[0] = 1'b0;
    repeat (D) cyc();
    chk("edge_pre", 32'(irq_req), 32'h0);
    cyc();
    chk("edge_req", 32'(irq_req), 32'h1);
    chk("edge_id", 32'(irq_id), 32'h1);
    rd(5, d); chk("edge_pend", d, 32'h2);
    pulse_ack();
    rd(5, d); chk("edge_clr", d, 32'h0);
    pulse_done();
    cyc();
    chk("edge_idle", 32'(irq_req), 32'h0);

    // priority and freeze: IDs 2 and 5, level mode
    wr(6, 0);
    wr(4, 32'h24);
    src_irq[4] = 1'b1;
    repeat (D + 2) cyc();
    chk("pri_req", 32'(irq_req), 32'h1);
    chk("pri_id5", 32'(irq_id), 32'h5);
    src_irq[1] = 1'b1;
    repeat (5) cyc();
    chk("pri_frozen", 32'(irq_id), 32'h5);
    pulse_ack();
    pulse_done();
    cyc();
    chk("pri_id2", 32'(irq_id), 32'h2);
    chk("pri_req2", 32'(irq_req), 32'h1);
    src_irq = '0;
    pulse_ack();
    pulse_done();
    repeat (6) cyc();

    // withdraw: level ID 3 drops before ack
    wr(4, 8);
    src_irq[2] = 1'b1;
    repeat (D + 2) cyc();
    chk("wd_req", 32'(irq_req), 32'h1);
    chk("wd_id", 32'(irq_id), 32'h3);
    src_irq[2] = 1'b0;
    repeat (D + 1) cyc();
    chk("wd_hold", 32'(irq_req), 32'h1);
    cyc();
    chk("wd_drop", 32'(irq_req), 32'h0);
    rd(7, d); chk("wd_status", d, 32'h3);

    // asynchronous reset while in service
    wr(2, 0);
    wr(3, 0);
    wr(4, 1);
    cyc();
    chk("ar_req", 32'(irq_req), 32'h1);
    pulse_ack();
    rd(7, d); chk("ar_svc", d, 32'h8000_0000);
    #3 rst = 1'b0;
    #1;
    chk("ar_req0", 32'(irq_req), 32'h0);
    chk("ar_id0", 32'(irq_id), 32'h0);
    chk("ar_rdata0", reg_rdata, 32'h0);
    @(posedge clk);
    #2 rst = 1'b1;
    rd(7, d); chk("ar_status", d, 32'h0);
    rd(5, d); chk("ar_pend", d, 32'h0);
    rd(1, d); chk("ar_mt_hi", d, 32'h0);
    rd(0, d); chk("ar_mt_lo_small", 32'(d < 8), 32'h1);
    rd(4, d); chk("ar_enable", d, 32'h0);

    // randomized traffic, checked every cycle by the model
    for (int c = 0; c < 4000; c++) begin
      for (int i = 0; i < NS; i++)
        if ($urandom_range(0, 15) == 0) src_irq[i] = ~src_irq[i];
      reg_wr = ($urandom_range(0, 9) == 0);
      reg_rd = ($urandom_range(0, 3) == 0);
      reg_addr = 3'($urandom_range(0, 7));
      case (reg_addr)
        3'd0: reg_wdata = $urandom_range(0, 40);
        3'd1: reg_wdata = 32'h0;
        3'd2: reg_wdata = $urandom_range(0, 300);
        3'd3: reg_wdata = ($urandom_range(0, 3) == 0)
                          ? 32'hFFFF_FFFF : 32'h0;
        default: reg_wdata = $urandom;
      endcase
      irq_ack = irq_req ? ($urandom_range(0, 2) == 0)
                        : ($urandom_range(0, 49) == 0);
      irq_done = ($urandom_range(0, 5) == 0);
      cyc();
    end
    reg_wr = 1'b0;
    reg_rd = 1'b0;
    irq_ack = 1'b0;
    irq_done = 1'b0;
    repeat (4) cyc();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
